// File: rtl/fg_sweep_sequencer_pkg.sv
// Shared definitions for the function-generator sweep sequencer:
// default widths, config-register address and FSM state encoding.
package fg_sweep_sequencer_pkg;

  localparam int FG_DATA_W  = 8;
  localparam int FG_ADDR_W  = 3;
  localparam int FG_DWELL_W = 16;

  // CR1 holds the prescaler/step value that a sweep normally walks through
  localparam logic [FG_ADDR_W-1:0] CR1_ADDR = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fg_dwell_timer.sv
// Dwell counter for the sweep sequencer: loaded on each accepted write,
// counts down while enabled and flags the final cycle of the dwell period.
module fg_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               expired_o
);

  logic [DWELL_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && count_q != '0) begin
      count_q <= count_q - DWELL_W'(1);
    end
  end

  // The period ends in the cycle the counter shows 1, so a load of N gives N cycles
  assign expired_o = (count_q == DWELL_W'(1));

endmodule

// File: rtl/fg_sweep_sequencer.sv
// Sweep controller: steps one config register from a start to a stop value,
// one handshaked write per dwell period, optionally repeating.
module fg_sweep_sequencer
  import fg_sweep_sequencer_pkg::*;
#(
  parameter int                DATA_W      = FG_DATA_W,
  parameter int                ADDR_W      = FG_ADDR_W,
  parameter int                DWELL_W     = FG_DWELL_W,
  parameter logic [ADDR_W-1:0] TARGET_ADDR = CR1_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               repeat_i,
  input  logic [DATA_W-1:0]  start_val_i,
  input  logic [DATA_W-1:0]  stop_val_i,
  input  logic [DATA_W-1:0]  step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               wr_req_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  input  logic               wr_ack_i,
  output logic               fg_enable_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  cur_val_o
);

  state_t state_q, state_d;

  logic [DATA_W-1:0]  start_q, stop_q, step_q, next_val_q, cur_val_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               repeat_q, dir_up_q, fg_en_q;

  logic               start_ok, accept, timer_expired, dwell_end, last_point;
  logic [DATA_W-1:0]  step_eff, stepped_val;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DATA_W:0]    sum_ext, diff_ext;

  assign start_ok   = (state_q == ST_IDLE) && start_i && !abort_i;
  assign accept     = (state_q == ST_WRITE) && wr_ack_i && !abort_i;
  assign dwell_end  = (state_q == ST_DWELL) && timer_expired && !abort_i;
  assign last_point = (cur_val_q == stop_q);

  assign step_eff  = (step_q == '0) ? DATA_W'(1) : step_q;
  assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  // One extra bit catches wrap past either end of the range before clamping
  assign sum_ext  = {1'b0, cur_val_q} + {1'b0, step_eff};
  assign diff_ext = {1'b0, cur_val_q} - {1'b0, step_eff};

  always_comb begin
    stepped_val = stop_q;
    if (dir_up_q) begin
      if (sum_ext < {1'b0, stop_q}) stepped_val = sum_ext[DATA_W-1:0];
    end else begin
      if (!diff_ext[DATA_W] && (diff_ext[DATA_W-1:0] > stop_q)) stepped_val = diff_ext[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_WRITE;
      ST_WRITE: begin
        if (abort_i)       state_d = ST_IDLE;
        else if (wr_ack_i) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (abort_i) state_d = ST_IDLE;
        else if (timer_expired) state_d = (last_point && !repeat_q) ? ST_DONE : ST_WRITE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      repeat_q   <= 1'b0;
      dir_up_q   <= 1'b0;
      next_val_q <= '0;
      cur_val_q  <= '0;
      fg_en_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        start_q    <= start_val_i;
        stop_q     <= stop_val_i;
        step_q     <= step_i;
        dwell_q    <= dwell_i;
        repeat_q   <= repeat_i;
        dir_up_q   <= (stop_val_i >= start_val_i);
        next_val_q <= start_val_i;
      end
      if (accept) begin
        cur_val_q <= next_val_q;
        fg_en_q   <= 1'b1;
      end
      if (dwell_end) next_val_q <= last_point ? start_q : stepped_val;
      if ((abort_i && state_q != ST_IDLE) || state_q == ST_DONE) fg_en_q <= 1'b0;
    end
  end

  fg_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (dwell_eff),
    .dec_i      (state_q == ST_DWELL),
    .expired_o  (timer_expired)
  );

  assign wr_req_o    = (state_q == ST_WRITE);
  assign wr_addr_o   = wr_req_o ? TARGET_ADDR : '0;
  assign wr_data_o   = wr_req_o ? next_val_q : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign fg_enable_o = fg_en_q;
  assign cur_val_o   = cur_val_q;

endmodule

// File: tb/tb_fg_sweep_sequencer.sv
// Scoreboard bench for fg_sweep_sequencer: directed sweeps push expected
// writes; a monitor pops and compares each accepted write.
module tb_fg_sweep_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0, repeat_i = 1'b0;
  logic [7:0]  start_val_i = '0, stop_val_i = '0, step_i = '0;
  logic [15:0] dwell_i = '0;
  logic        wr_req_o, wr_ack_i = 1'b0;
  logic [2:0]  wr_addr_o;
  logic [7:0]  wr_data_o, cur_val_o;
  logic        fg_enable_o, busy_o, done_o;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, last_acc = 0, done_cyc = 0, done_cnt = 0;
  int   ack_delay = 0, stall_cnt = 0;

  fg_sweep_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .repeat_i    (repeat_i),
    .start_val_i (start_val_i),
    .stop_val_i  (stop_val_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_ack_i    (wr_ack_i),
    .fg_enable_o (fg_enable_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cur_val_o   (cur_val_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] d, input int g);
    exp_t e;
    e.data = d;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] sv, input logic [7:0] pv, input logic [7:0] st,
                               input logic [15:0] dw, input logic rep);
    @(negedge clk_i);
    start_val_i = sv;
    stop_val_i  = pv;
    step_i      = st;
    dwell_i     = dw;
    repeat_i    = rep;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    repeat_i = 1'b0;
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    #2;
    if (busy_o) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: busy_o still %0d after %0d cycles, required 0", name, busy_o, limit);
    end
  endtask

  // Bank model: hold off ack for ack_delay cycles of a pending request
  always @(negedge clk_i) begin
    if (wr_req_o && !wr_ack_i) begin
      if (stall_cnt >= ack_delay) begin
        wr_ack_i  = 1'b1;
        stall_cnt = 0;
      end else begin
        stall_cnt++;
      end
    end else begin
      wr_ack_i = 1'b0;
      if (!wr_req_o) stall_cnt = 0;
    end
  end

  always @(negedge clk_i) begin
    #1;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_req_o && wr_ack_i) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected write: data %0d accepted, no write expected", wr_data_o);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("write data", {24'd0, wr_data_o}, {24'd0, mon_e.data});
        checkOutput("write addr", {29'd0, wr_addr_o}, 32'd1);
        if (mon_e.gap != 0) checkOutput("write spacing", cyc - last_acc, mon_e.gap);
      end
      last_acc = cyc;
    end else if (wr_req_o && sb.size() != 0) begin
      checkOutput("stalled write data", {24'd0, wr_data_o}, {24'd0, sb[0].data});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0, n, glitch;

    repeat (2) @(negedge clk_i);
    #2;
    checkOutput("reset wr_req", wr_req_o, 0);
    checkOutput("reset wr_addr", wr_addr_o, 0);
    checkOutput("reset wr_data", wr_data_o, 0);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset done", done_o, 0);
    checkOutput("reset fg_enable", fg_enable_o, 0);
    checkOutput("reset cur_val", cur_val_o, 0);
    rst_i = 1'b0;

    $display("[TB] T1 up sweep 10..40 step 10 dwell 3");
    pushExp(8'd10, 0); pushExp(8'd20, 4); pushExp(8'd30, 4); pushExp(8'd40, 4);
    d0 = done_cnt;
    applyStimulus(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
    waitIdle(200, "T1");
    checkOutput("T1 pending writes", sb.size(), 0);
    checkOutput("T1 done pulses", done_cnt - d0, 1);
    checkOutput("T1 dwell before done", done_cyc - last_acc, 4);
    checkOutput("T1 fg_enable after", fg_enable_o, 0);
    checkOutput("T1 cur_val", cur_val_o, 40);

    $display("[TB] T2 down sweep with clamp, and top-of-range clamp");
    pushExp(8'd50, 0); pushExp(8'd30, 0); pushExp(8'd10, 0); pushExp(8'd5, 0);
    d0 = done_cnt;
    applyStimulus(8'd50, 8'd5, 8'd20, 16'd1, 1'b0);
    waitIdle(200, "T2a");
    checkOutput("T2a pending writes", sb.size(), 0);
    checkOutput("T2a cur_val", cur_val_o, 5);
    checkOutput("T2a done pulses", done_cnt - d0, 1);
    pushExp(8'd250, 0); pushExp(8'd255, 0);
    applyStimulus(8'd250, 8'd255, 8'd10, 16'd1, 1'b0);
    waitIdle(200, "T2b");
    checkOutput("T2b pending writes", sb.size(), 0);
    checkOutput("T2b cur_val", cur_val_o, 255);

    $display("[TB] T3 handshake stall of 5 cycles");
    ack_delay = 5;
    pushExp(8'd100, 0); pushExp(8'd115, 8); pushExp(8'd130, 8);
    applyStimulus(8'd100, 8'd130, 8'd15, 16'd2, 1'b0);
    waitIdle(400, "T3");
    checkOutput("T3 pending writes", sb.size(), 0);
    checkOutput("T3 cur_val", cur_val_o, 130);
    ack_delay = 0;

    $display("[TB] T4 repeat sweep then abort in dwell");
    pushExp(8'd0, 0); pushExp(8'd1, 3); pushExp(8'd2, 3); pushExp(8'd0, 3); pushExp(8'd1, 3);
    d0 = done_cnt;
    applyStimulus(8'd0, 8'd2, 8'd1, 16'd2, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    checkOutput("T4 pending writes", sb.size(), 0);
    @(negedge clk_i);
    abort_i = 1'b1;
    #2;
    checkOutput("T4 busy in dwell", busy_o, 1);
    checkOutput("T4 fg_enable in dwell", fg_enable_o, 1);
    @(negedge clk_i);
    abort_i = 1'b0;
    #2;
    checkOutput("T4 busy after abort", busy_o, 0);
    checkOutput("T4 wr_req after abort", wr_req_o, 0);
    checkOutput("T4 fg_enable after abort", fg_enable_o, 0);
    checkOutput("T4 cur_val held", cur_val_o, 1);
    repeat (4) @(negedge clk_i);
    #2;
    checkOutput("T4 still idle", busy_o, 0);
    checkOutput("T4 no done pulse", done_cnt - d0, 0);

    $display("[TB] T5 step 0, dwell 0, single point");
    pushExp(8'd7, 0);
    d0 = done_cnt;
    applyStimulus(8'd7, 8'd7, 8'd0, 16'd0, 1'b0);
    waitIdle(100, "T5");
    checkOutput("T5 pending writes", sb.size(), 0);
    checkOutput("T5 done pulses", done_cnt - d0, 1);
    checkOutput("T5 one-cycle dwell", done_cyc - last_acc, 2);
    checkOutput("T5 cur_val", cur_val_o, 7);
    @(negedge clk_i);
    start_val_i = 8'd3;
    stop_val_i  = 8'd9;
    start_i     = 1'b1;
    abort_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    #2;
    checkOutput("T5 start+abort busy", busy_o, 0);
    @(negedge clk_i);
    #2;
    checkOutput("T5 start+abort wr_req", wr_req_o, 0);

    $display("[TB] T6 async reset during write");
    ack_delay = 20;
    pushExp(8'd60, 0);
    applyStimulus(8'd60, 8'd70, 8'd5, 16'd1, 1'b0);
    #2;
    checkOutput("T6 wr_req before reset", wr_req_o, 1);
    rst_i = 1'b1;
    #1;
    checkOutput("T6 wr_req in reset", wr_req_o, 0);
    checkOutput("T6 busy in reset", busy_o, 0);
    checkOutput("T6 cur_val in reset", cur_val_o, 0);
    checkOutput("T6 wr_data in reset", wr_data_o, 0);
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    glitch = 0;
    repeat (5) begin
      @(negedge clk_i);
      #2;
      if (wr_req_o || busy_o) glitch++;
    end
    checkOutput("T6 quiet after release", glitch, 0);
    ack_delay = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
